// File: rtl/alu_seq_pkg.sv
// Shared state encoding, opcodes and op-table lookup for alu_op_sequencer.
package alu_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH_A = 3'd1;
    localparam logic [2:0] ST_LOAD_A  = 3'd2;
    localparam logic [2:0] ST_FETCH_B = 3'd3;
    localparam logic [2:0] ST_LOAD_B  = 3'd4;
    localparam logic [2:0] ST_EXEC    = 3'd5;
    localparam logic [2:0] ST_STORE   = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_MUL = 2'b10;

    // Two bits per op, op 0 in the LSBs
    function automatic logic [1:0] op_code(input logic [31:0] tbl, input logic [3:0] idx);
        return tbl[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/mul_iter_counter.sv
// Multiply iteration counter: loads the iteration count from B, steps down once per
// accumulation and flags the final pass. SIGNED_MUL_EN loads |B| for a two's-complement B.
module mul_iter_counter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              dec,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] count,
    output logic              last,
    output logic              b_zero
);

    localparam logic [DATA_W-1:0] ONE_C  = DATA_W'(1);
    localparam logic [DATA_W-1:0] ZERO_C = {DATA_W{1'b0}};

    logic [DATA_W-1:0] mag_s;
    logic [DATA_W-1:0] count_r;

    // Iteration count implied by B (-128 maps to 128, which still fits unsigned)
    always_comb begin
        mag_s = b;
`ifdef SIGNED_MUL_EN
        if (b[DATA_W-1]) begin
            mag_s = (~b) + ONE_C;
        end else begin
            mag_s = b;
        end
`endif
    end

    // Remaining-iteration register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_C;
        end else if (load) begin
            count_r <= mag_s;
        end else if (dec) begin
            count_r <= count_r - ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign last   = (count_r == ONE_C);
    assign b_zero = (mag_s == ZERO_C);

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the shared ROM + ALU/accumulator datapath through a fixed NUM_OPS schedule.
// Optional macro SIGNED_MUL_EN: mul treats B as two's-complement (negative B subtracts A).
module alu_op_sequencer #(
    parameter int          ADDR_W   = 9,
    parameter int          DATA_W   = 8,
    parameter int          NUM_OPS  = 4,
    parameter int          OP_BASE  = 0,
    parameter logic [31:0] OP_TABLE = 32'b10_10_00_01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              en_a,
    output logic              en_b,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              op_sub,
    output logic              sel_mul,
    output logic              en_c,
    output logic [3:0]        op_idx,
    output logic [DATA_W-1:0] count,
    output logic              busy,
    output logic              done
);
    import alu_seq_pkg::*;

    localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(OP_BASE);
    localparam logic [3:0]        LAST_IDX = 4'(NUM_OPS - 1);

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [3:0]        op_idx_r;
    logic              en_a_r, en_b_r, acc_clr_r, acc_en_r, en_c_r;
    logic              op_sub_r, sel_mul_r, busy_r, done_r;

    logic [1:0]        opc_s;
    logic              is_mul_s, is_sub_s;
    logic              cnt_load_s, cnt_dec_s, cnt_last_s, b_zero_s;
    logic [3:0]        idx_nxt_s;
    logic [ADDR_W-1:0] addr_b_s, addr_nxt_s;

    // Current-op decode, counter controls and next ROM addresses
    always_comb begin
        opc_s    = op_code(OP_TABLE, op_idx_r);
        is_mul_s = 1'b0;
        is_sub_s = 1'b0;
        case (opc_s)
            OPC_ADD: is_sub_s = 1'b0;
            OPC_SUB: is_sub_s = 1'b1;
            OPC_MUL: is_mul_s = 1'b1;
            default: is_sub_s = 1'b0;
        endcase
        cnt_load_s = (state_r == ST_LOAD_B) && sel_mul_r;
        cnt_dec_s  = (state_r == ST_EXEC);
        idx_nxt_s  = op_idx_r + 4'd1;
        addr_b_s   = BASE_C + ADDR_W'({op_idx_r, 1'b1});
        addr_nxt_s = BASE_C + ADDR_W'({idx_nxt_s, 1'b0});
    end

    mul_iter_counter #(.DATA_W(DATA_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load_s),
        .dec    (cnt_dec_s),
        .b      (rom_data),
        .count  (count),
        .last   (cnt_last_s),
        .b_zero (b_zero_s)
    );

    // Schedule FSM; every output is registered and strobes are set for the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rom_addr_r <= {ADDR_W{1'b0}};
            op_idx_r   <= 4'd0;
            en_a_r     <= 1'b0;
            en_b_r     <= 1'b0;
            acc_clr_r  <= 1'b0;
            acc_en_r   <= 1'b0;
            en_c_r     <= 1'b0;
            op_sub_r   <= 1'b0;
            sel_mul_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            en_a_r    <= 1'b0;
            en_b_r    <= 1'b0;
            acc_clr_r <= 1'b0;
            acc_en_r  <= 1'b0;
            en_c_r    <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_FETCH_A;
                        op_idx_r   <= 4'd0;
                        rom_addr_r <= BASE_C;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH_A: begin
                    state_r <= ST_LOAD_A;
                    en_a_r  <= 1'b1;
                end
                ST_LOAD_A: begin
                    state_r    <= ST_FETCH_B;
                    rom_addr_r <= addr_b_s;
                end
                ST_FETCH_B: begin
                    state_r   <= ST_LOAD_B;
                    en_b_r    <= 1'b1;
                    acc_clr_r <= is_mul_s;
                    sel_mul_r <= is_mul_s;
                    op_sub_r  <= is_sub_s;
                end
                ST_LOAD_B: begin
                    if (sel_mul_r && !b_zero_s) begin
                        state_r  <= ST_EXEC;
                        acc_en_r <= 1'b1;
`ifdef SIGNED_MUL_EN
                        op_sub_r <= rom_data[DATA_W-1];
`endif
                    end else begin
                        state_r <= ST_STORE;
                        en_c_r  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cnt_last_s) begin
                        state_r <= ST_STORE;
                        en_c_r  <= 1'b1;
                    end else begin
                        acc_en_r <= 1'b1;
                    end
                end
                ST_STORE: begin
                    op_sub_r  <= 1'b0;
                    sel_mul_r <= 1'b0;
                    if (op_idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r    <= ST_FETCH_A;
                        op_idx_r   <= idx_nxt_s;
                        rom_addr_r <= addr_nxt_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = rom_addr_r;
    assign en_a     = en_a_r;
    assign en_b     = en_b_r;
    assign acc_clr  = acc_clr_r;
    assign acc_en   = acc_en_r;
    assign op_sub   = op_sub_r;
    assign sel_mul  = sel_mul_r;
    assign en_c     = en_c_r;
    assign op_idx   = op_idx_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ROM + datapath around the DUT, results checked against plain arithmetic.
module tb_alu_op_sequencer;

    localparam int NOPS = 4;
    localparam int TBL  = 'hA1;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic start1 = 1'b0;

    logic [7:0] rom [0:511];
    logic [7:0] rom_q, rom_q1, ra, rb, acc, ra1, rb1;

    logic [8:0] rom_addr, rom_addr1;
    logic       en_a, en_b, acc_clr, acc_en, op_sub, sel_mul, en_c, busy, done;
    logic       en_a1, en_b1, acc_clr1, acc_en1, op_sub1, sel_mul1, en_c1, busy1, done1;
    logic [3:0] op_idx, op_idx1;
    logic [7:0] count, count1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .rom_data(rom_q), .rom_addr(rom_addr),
        .en_a(en_a), .en_b(en_b), .acc_clr(acc_clr), .acc_en(acc_en), .op_sub(op_sub),
        .sel_mul(sel_mul), .en_c(en_c), .op_idx(op_idx), .count(count), .busy(busy), .done(done)
    );

    alu_op_sequencer #(.NUM_OPS(1), .OP_TABLE(32'h1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rom_data(rom_q1), .rom_addr(rom_addr1),
        .en_a(en_a1), .en_b(en_b1), .acc_clr(acc_clr1), .acc_en(acc_en1), .op_sub(op_sub1),
        .sel_mul(sel_mul1), .en_c(en_c1), .op_idx(op_idx1), .count(count1), .busy(busy1), .done(done1)
    );

    // Synchronous ROM and operand/accumulator datapath driven by the sequencer strobes
    always @(posedge clk) begin
        rom_q  <= rom[rom_addr];
        rom_q1 <= rom[rom_addr1];
        if (en_a) ra <= rom_q;
        if (en_b) rb <= rom_q;
        if (acc_clr) acc <= 8'd0;
        else if (acc_en) acc <= op_sub ? acc - ra : acc + ra;
        if (en_a1) ra1 <= rom_q1;
        if (en_b1) rb1 <= rom_q1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int opc_of(input int i);
        return (TBL >> (2 * i)) & 3;
    endfunction

    function automatic int iters_of(input int opc, input logic [7:0] b);
        if (opc != 2) return 0;
`ifdef SIGNED_MUL_EN
        if (b[7]) return 256 - int'(b);
`endif
        return int'(b);
    endfunction

    function automatic logic [7:0] exp_res(input int opc, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        case (opc)
            1:       return a - b;
            2:       return p[7:0];
            default: return a + b;
        endcase
    endfunction

    function automatic logic exp_sub(input int opc, input logic [7:0] b);
`ifdef SIGNED_MUL_EN
        if (opc == 2) return b[7];
`endif
        return (opc == 1);
    endfunction

    function automatic logic [31:0] out_vec();
        return {2'b00, rom_addr, en_a, en_b, acc_clr, acc_en, op_sub, sel_mul, en_c,
                op_idx, count, busy, done};
    endfunction

    task automatic load_rom(input logic [7:0] v [8]);
        for (int i = 0; i < 8; i++) rom[i] = v[i];
    endtask

    task automatic load_random();
        logic [7:0] b;
        for (int i = 0; i < NOPS; i++) begin
            rom[2*i] = 8'($urandom);
            if (opc_of(i) == 2) begin
                b = 8'($urandom_range(0, 40));
                if ($urandom_range(0, 1) == 1) b = 8'd0 - b;
            end else begin
                b = 8'($urandom);
            end
            rom[2*i+1] = b;
        end
    endtask

    // Caller sits at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE
    task automatic run_sched(input bit hold);
        int n, opn, acc_cnt, clr_cnt, busy_bad, sub_bad, exp_total, last_cnt, opc;
        logic [7:0] a, b, got;
        exp_total = 1;
        for (int i = 0; i < NOPS; i++) exp_total += 5 + iters_of(opc_of(i), rom[2*i+1]);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        n = 1; opn = 0; acc_cnt = 0; clr_cnt = 0; busy_bad = 0; sub_bad = 0; last_cnt = 0;
        while (done !== 1'b1 && n <= exp_total + 8) begin
            opc = opc_of(opn);
            a = rom[2*opn];
            b = rom[2*opn+1];
            if (busy !== 1'b1) busy_bad++;
            if (en_a === 1'b1) begin
                check_eq("addr_a", 32'(rom_addr), 2 * opn);
                check_eq("idx_a", 32'(op_idx), opn);
            end
            if (en_b === 1'b1) check_eq("addr_b", 32'(rom_addr), 2 * opn + 1);
            if (acc_clr === 1'b1) clr_cnt++;
            if (acc_en === 1'b1) begin
                if (acc_cnt == 0) check_eq("cnt_first", 32'(count), iters_of(opc, b));
                acc_cnt++;
                last_cnt = int'(count);
                if (op_sub !== exp_sub(opc, b)) sub_bad++;
            end
            if (en_c === 1'b1) begin
                got = sel_mul ? acc : (op_sub ? ra - rb : ra + rb);
                check_eq("result", 32'(got), 32'(exp_res(opc, a, b)));
                check_eq("op_sub", 32'(op_sub), 32'(exp_sub(opc, b)));
                check_eq("sel_mul", 32'(sel_mul), 32'(opc == 2));
                check_eq("acc_en_n", acc_cnt, iters_of(opc, b));
                check_eq("acc_clr_n", clr_cnt, 32'(opc == 2));
                check_eq("idx_c", 32'(op_idx), opn);
                if (acc_cnt > 0) check_eq("cnt_last", last_cnt, 1);
                opn++;
                acc_cnt = 0;
                clr_cnt = 0;
            end
            @(negedge clk);
            n++;
        end
        check_eq("done_lat", n, exp_total);
        check_eq("ops", opn, NOPS);
        check_eq("busy_run", busy_bad, 0);
        check_eq("exec_sub", sub_bad, 0);
        check_eq("busy_done", 32'(busy), 1);
        @(negedge clk);
        check_eq("idle_after", {30'd0, busy, done}, 0);
    endtask

    task automatic run_single();
        int n;
        logic [7:0] a1, b1;
        a1 = rom[0];
        b1 = rom[1];
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (done1 !== 1'b1 && n < 20) begin
            if (en_a1 === 1'b1) check_eq("s_addr_a", 32'(rom_addr1), 0);
            if (en_b1 === 1'b1) check_eq("s_addr_b", 32'(rom_addr1), 1);
            if (en_c1 === 1'b1) begin
                check_eq("s_result", 32'(8'(ra1 - rb1)), 32'(8'(a1 - b1)));
                check_eq("s_ctl", {16'd0, op_sub1, sel_mul1, acc_clr1, acc_en1, op_idx1, count1},
                         32'h8000);
            end
            @(negedge clk);
            n++;
        end
        check_eq("s_done_lat", n, 6);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        int n, seen, stray;
        n = 0; seen = 0; stray = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (seen < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (acc_en === 1'b1 && op_idx == 4'd2) seen++;
        end
        check_eq("exec_reach", seen, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_eq("reset_mid", out_vec(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (en_c !== 1'b0 || busy !== 1'b0) stray++;
        end
        check_eq("no_en_c", stray, 0);
    endtask

    initial begin
        logic [7:0] dir [8];
        dir = '{8'd5, 8'd3, 8'd7, 8'd2, 8'd4, 8'd3, 8'd9, 8'd0};
        for (int i = 0; i < 512; i++) rom[i] = 8'd0;
        load_rom(dir);
        repeat (3) @(negedge clk);
        check_eq("reset_state", out_vec(), 0);
        rst = 1'b0;
        @(negedge clk);

        run_single();
        run_sched(1'b0);
        rom[5] = 8'd255;
        run_sched(1'b0);
        rom[4] = 8'd6;
        rom[5] = 8'hFE;
        run_sched(1'b0);
        repeat (6) begin
            load_random();
            run_sched(1'b0);
        end
        load_random();
        run_sched(1'b1);
        run_sched(1'b1);
        start = 1'b0;
        @(negedge clk);

        load_rom(dir);
        rom[5] = 8'd10;
        mid_reset();
        run_sched(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
